id_hazard_ctrl: RTL
===================

# id_hazard_ctrl

Interlock and forwarding controller for the five-stage MIPS pipeline, placed beside the decode stage. It tracks the destination registers of the instructions in EX, MEM and WB, and from them drives the decode stage's `rs_sel`/`rt_sel` forwarding selects and the decode stall. It also sequences the multi-cycle DIV/DIVU unit that writes HI/LO, interlocking later HI/LO users until the result retires. On a CP0 exception/ERET flush it discards in-flight state.

## Interface
Parameters:
- `DIV_CYCLES`, default 32: execute cycles of one DIV/DIVU; legal range 2..63.

Ports (clock and reset first):
- `clk` in 1: single clock; all state updates on its rising edge.
- `resetn` in 1: reset, asynchronous and active-low.
- `id_valid` in 1: decode holds a real instruction; 0 means bubble.
- `id_rs` in 5: decode source 1; 0 means unused.
- `id_rt` in 5: decode source 2; 0 means unused.
- `id_rd` in 5: decode destination.
- `id_rf_we` in 1: decode instruction writes `id_rd`.
- `id_is_load` in 1: decode instruction is a load.
- `id_md_start` in 1: decode instruction is DIV/DIVU.
- `id_hilo_use` in 1: decode instruction reads or writes HI/LO (MFHI, MFLO, MTHI, MTLO, MULT, MULTU).
- `flush` in 1: CP0 exception or ERET flush.
- `stall` out 1: hold IF/ID; a bubble is inserted into EX.
- `rs_sel` out 2: forwarding select for source 1.
- `rt_sel` out 2: forwarding select for source 2.
- `md_start` out 1: one-cycle launch pulse to the divider.
- `md_busy` out 1: a divide is in flight.
- `md_done` out 1: one-cycle pulse; divider writes HI/LO this cycle.
- `md_abort` out 1: one-cycle pulse; the in-flight divide is cancelled and HI/LO are not written.

## Operation
- Internal tracking registers: `ex_`, `mem_` and `wb_` each hold {valid, rd, we, is_load}.
  - When `stall`=0, the ID instruction moves to EX.
  - When `stall`=1, EX receives valid=0. MEM and WB always advance.
- A source matches a stage when the source register is nonzero, the stage is valid, the stage has we=1, and the stage rd equals the source.
- Forward select encoding: 00 = regfile, 01 = EX result, 10 = MEM result, 11 = WB data. Priority is EX > MEM > WB (youngest wins).
- Load-use stall: a match against a stage with is_load=1 in EX or MEM stalls. Load data is available only from WB.
- Divider FSM states: IDLE, BUSY, DONE.
  - IDLE → BUSY: `id_valid & id_md_start & !stall`. `md_start` pulses that cycle and the counter loads `DIV_CYCLES-1`.
  - BUSY: the counter decrements each cycle. At 0 the FSM goes to DONE.
  - DONE: `md_done`=1 for one cycle, then the FSM returns to IDLE.
- HI/LO interlock: `stall`=1 when `id_valid` and (`id_md_start` or `id_hilo_use`) and the FSM is in BUSY or DONE.
- Flush behaviour:
  - EX and MEM valids clear; WB is unaffected.
  - If the FSM is BUSY, it goes to IDLE and `md_abort` pulses.
  - If the FSM is in DONE, the divide completes normally and is not aborted.
  - `stall` is forced to 0 in the flush cycle.
- `stall`, `rs_sel` and `rt_sel` are combinational from current state and ID inputs. `md_*` outputs are registered.

## Timing
- Reset values:
  - All valids = 0.
  - FSM = IDLE, counter = 0.
  - `md_start`, `md_done`, `md_abort`, `md_busy` = 0.
  - `stall` = 0, `rs_sel`/`rt_sel` = 00 (given idle ID inputs).
- Reset asserted mid-divide returns to IDLE immediately, with no `md_done` and no `md_abort`.
- Load-use latency:
  - Load in EX with a dependent instruction in ID: 2 stall cycles, then `*_sel`=11.
  - Dependent instruction issued one slot after the load: 1 stall cycle.
- Divide latency: `md_start` at cycle T, `md_done` at T+`DIV_CYCLES`. A HI/LO user in ID is released at T+`DIV_CYCLES`+1.
- Simultaneous events:
  - `flush` overrides `stall` and launch; no `md_start` is issued in a flush cycle.
  - A BUSY→DONE transition and a flush in the same cycle resolve as abort.
- Register 0 is never forwarded and never causes a stall.

## Configuration
- `HAZ_FWD_EN` defined: forwarding as described above.
- `HAZ_FWD_EN` undefined:
  - `rs_sel`/`rt_sel` are tied to 00.
  - Any match in EX, MEM or WB stalls, so the sole source of operand data is the regfile, read after write-back.
  - All other behaviour is unchanged.

## Test plan
- ADDU r3 in EX, ID reads rs=r3 → `rs_sel`=01, `stall`=0. Next cycle, with r3 in MEM → `rs_sel`=10.
- LW r5 in EX, ID `rt`=r5 → `stall`=1 for 2 cycles, then `rt_sel`=11. A source of r0 with a `rd`=0 load never stalls.
- DIV with `DIV_CYCLES`=4 at T → `md_done` at T+4; an MFLO held in ID stalls until T+5.
- DIV at T, `flush` at T+2 → `md_abort` pulse at T+3, no `md_done`, MFLO not stalled afterwards.
- Build without `HAZ_FWD_EN`: ADDU r3 then a reader of r3 → 3 stall cycles, selects stay 00.
- `resetn` low mid-divide → all outputs 0 asynchronously; after release, a new DIV launches normally.

Source files
------------

// File: rtl/id_hazard_ctrl.sv
`default_nettype none
// id_hazard_ctrl: decode-side interlock, operand-forwarding select and DIV/DIVU sequencer.
// Define HAZ_FWD_EN to enable EX/MEM/WB forwarding; otherwise every RAW match stalls.
module id_hazard_ctrl #(
  parameter int unsigned DIV_CYCLES = 32
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       id_valid,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic [4:0] id_rd,
  input  logic       id_rf_we,
  input  logic       id_is_load,
  input  logic       id_md_start,
  input  logic       id_hilo_use,
  input  logic       flush,
  output logic       stall,
  output logic [1:0] rs_sel,
  output logic [1:0] rt_sel,
  output logic       md_start,
  output logic       md_busy,
  output logic       md_done,
  output logic       md_abort
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } div_state_t;

  localparam logic [5:0] CNT_LOAD = 6'(DIV_CYCLES - 1);

  logic       ex_valid_q, mem_valid_q, wb_valid_q;
  logic [4:0] ex_rd_q, mem_rd_q, wb_rd_q;
  logic       ex_we_q, mem_we_q, wb_we_q;
  logic       ex_ld_q, mem_ld_q;

  div_state_t state_q, state_d;
  logic [5:0] cnt_q, cnt_d;
  logic       md_start_q, md_start_d;
  logic       md_busy_q, md_busy_d;
  logic       md_done_q, md_done_d;
  logic       md_abort_q, md_abort_d;

  logic rs_ex, rs_mem, rs_wb, rt_ex, rt_mem, rt_wb;
  logic data_haz, hilo_haz;

  assign rs_ex  = (id_rs != 5'd0) && ex_valid_q  && ex_we_q  && (ex_rd_q  == id_rs);
  assign rs_mem = (id_rs != 5'd0) && mem_valid_q && mem_we_q && (mem_rd_q == id_rs);
  assign rs_wb  = (id_rs != 5'd0) && wb_valid_q  && wb_we_q  && (wb_rd_q  == id_rs);
  assign rt_ex  = (id_rt != 5'd0) && ex_valid_q  && ex_we_q  && (ex_rd_q  == id_rt);
  assign rt_mem = (id_rt != 5'd0) && mem_valid_q && mem_we_q && (mem_rd_q == id_rt);
  assign rt_wb  = (id_rt != 5'd0) && wb_valid_q  && wb_we_q  && (wb_rd_q  == id_rt);

`ifdef HAZ_FWD_EN
  // Load data only exists at WB, so a load match in EX or MEM must wait.
  assign data_haz = ((rs_ex | rt_ex) & ex_ld_q) | ((rs_mem | rt_mem) & mem_ld_q);
  assign rs_sel   = rs_ex ? 2'b01 : rs_mem ? 2'b10 : rs_wb ? 2'b11 : 2'b00;
  assign rt_sel   = rt_ex ? 2'b01 : rt_mem ? 2'b10 : rt_wb ? 2'b11 : 2'b00;
`else
  logic unused_ld;
  assign unused_ld = ex_ld_q ^ mem_ld_q;
  assign data_haz  = rs_ex | rs_mem | rs_wb | rt_ex | rt_mem | rt_wb;
  assign rs_sel    = 2'b00;
  assign rt_sel    = 2'b00;
`endif

  assign hilo_haz = (id_md_start | id_hilo_use) && (state_q != S_IDLE);
  assign stall    = !flush && id_valid && (data_haz || hilo_haz);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ex_valid_q  <= 1'b0;
      mem_valid_q <= 1'b0;
      wb_valid_q  <= 1'b0;
      ex_rd_q     <= 5'd0;
      mem_rd_q    <= 5'd0;
      wb_rd_q     <= 5'd0;
      ex_we_q     <= 1'b0;
      mem_we_q    <= 1'b0;
      wb_we_q     <= 1'b0;
      ex_ld_q     <= 1'b0;
      mem_ld_q    <= 1'b0;
    end else begin
      ex_valid_q  <= id_valid && !stall && !flush;
      ex_rd_q     <= id_rd;
      ex_we_q     <= id_rf_we;
      ex_ld_q     <= id_is_load;
      mem_valid_q <= ex_valid_q && !flush;
      mem_rd_q    <= ex_rd_q;
      mem_we_q    <= ex_we_q;
      mem_ld_q    <= ex_ld_q;
      wb_valid_q  <= mem_valid_q;
      wb_rd_q     <= mem_rd_q;
      wb_we_q     <= mem_we_q;
    end
  end

  // A flush only cancels a divide still counting; one already in DONE retires.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    md_start_d = 1'b0;
    md_done_d  = 1'b0;
    md_abort_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (id_valid && id_md_start && !stall && !flush) begin
          state_d    = S_BUSY;
          cnt_d      = CNT_LOAD;
          md_start_d = 1'b1;
        end
      end
      S_BUSY: begin
        if (flush) begin
          state_d    = S_IDLE;
          cnt_d      = 6'd0;
          md_abort_d = 1'b1;
        end else if (cnt_q == 6'd0) begin
          state_d   = S_DONE;
          md_done_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 6'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    md_busy_d = (state_d == S_BUSY);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      cnt_q      <= 6'd0;
      md_start_q <= 1'b0;
      md_busy_q  <= 1'b0;
      md_done_q  <= 1'b0;
      md_abort_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      md_start_q <= md_start_d;
      md_busy_q  <= md_busy_d;
      md_done_q  <= md_done_d;
      md_abort_q <= md_abort_d;
    end
  end

  assign md_start = md_start_q;
  assign md_busy  = md_busy_q;
  assign md_done  = md_done_q;
  assign md_abort = md_abort_q;

endmodule
`default_nettype wire
